// File: rtl/imem_line_fill_responder_if.sv
// Line-fill handshake between the I-cache and its responder, plus the
// responder's read port onto the instruction RAM.
interface imem_line_fill_responder_if #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 10
);
  logic                      mem_r;
  logic [31:0]               mem_addr;
  logic                      mem_ready;
  logic [32*LINE_WORDS-1:0]  mem_line;
  logic                      ram_en;
  logic [ADDR_W-1:0]         ram_addr;
  logic [31:0]               ram_dout;

  // responder side
  modport slave (
    input  mem_r, mem_addr, ram_dout,
    output mem_ready, mem_line, ram_en, ram_addr
  );

  // cache controller plus backing RAM
  modport master (
    output mem_r, mem_addr, ram_dout,
    input  mem_ready, mem_line, ram_en, ram_addr
  );
endinterface

// File: rtl/imem_line_fill_responder.sv
// Memory-side I-cache line-fill responder: streams one line out of a
// synchronous RAM, assembles it and hands it back with a one-cycle ready.
module imem_line_fill_responder #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  imem_line_fill_responder_if.slave    bus,
  output logic [15:0]                  fill_count
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = OFF_W + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]                       state;
  logic [ADDR_W-OFF_W-1:0]          line_tag;
  logic [OFF_W-1:0]                 issue_cnt;
  logic [CNT_W-1:0]                 cap_cnt;
  logic [CNT_W-1:0]                 cap_cnt_next;
  logic [RAM_LAT-1:0]               inflight_vld;
  logic [RAM_LAT-1:0][OFF_W-1:0]    inflight_idx;
  logic [LINE_WORDS-1:0][31:0]      line_q;
  logic                             cap_fire;
  logic                             unused_addr_bits;

  assign cap_fire     = inflight_vld[RAM_LAT-1];
  assign cap_cnt_next = cap_cnt + CNT_W'(cap_fire);

  // Line base keeps only the tag; the offset comes straight from issue_cnt,
  // so the read address wraps inside the line by construction.
  assign bus.ram_en    = (state == ISSUE);
  assign bus.ram_addr  = {line_tag, issue_cnt};
  assign bus.mem_ready = (state == DONE) && bus.mem_r;
  assign bus.mem_line  = line_q;

  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[OFF_W+1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      line_tag     <= '0;
      issue_cnt    <= '0;
      cap_cnt      <= '0;
      inflight_vld <= '0;
      inflight_idx <= '0;
      line_q       <= '0;
      fill_count   <= '0;
    end else begin
      for (int unsigned i = RAM_LAT - 1; i > 0; i--) begin
        inflight_vld[i] <= inflight_vld[i-1];
        inflight_idx[i] <= inflight_idx[i-1];
      end
      inflight_vld[0] <= bus.ram_en;
      inflight_idx[0] <= issue_cnt;

      if (cap_fire) begin
        line_q[inflight_idx[RAM_LAT-1]] <= bus.ram_dout;
        cap_cnt <= cap_cnt_next;
      end

      case (state)
        IDLE: begin
          if (bus.mem_r) begin
            line_tag  <= bus.mem_addr[ADDR_W+1:OFF_W+2];
            issue_cnt <= '0;
            cap_cnt   <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == '1)
            state <= DRAIN;
        end
        DRAIN: begin
          // Look at the post-capture count so DONE follows the last capture directly.
          if (cap_cnt_next == CNT_W'(LINE_WORDS))
            state <= DONE;
        end
        DONE: begin
          if (bus.mem_r && (fill_count != '1))
            fill_count <= fill_count + 16'd1;
          state <= HOLD;
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_line_fill_responder.sv
// Directed bench for imem_line_fill_responder: default build plus a
// RAM_LAT=3 build, each fed by a behavioural RAM holding 0x10000000+i.
module tb_imem_line_fill_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst3;
  logic [15:0] fill_count;
  logic [15:0] fill_count3;
  logic [31:0] r3_a;
  logic [31:0] r3_b;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  imem_line_fill_responder_if #(.LINE_WORDS(4), .ADDR_W(10)) bus  ();
  imem_line_fill_responder_if #(.LINE_WORDS(4), .ADDR_W(10)) bus3 ();

  imem_line_fill_responder #(.LINE_WORDS(4), .RAM_LAT(1), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fill_count (fill_count)
  );

  imem_line_fill_responder #(.LINE_WORDS(4), .RAM_LAT(3), .ADDR_W(10)) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .bus        (bus3),
    .fill_count (fill_count3)
  );

  // Backing RAMs; idle cycles return a poison word so mistimed captures show.
  always_ff @(posedge clk)
    bus.ram_dout <= bus.ram_en ? (32'h1000_0000 | {22'd0, bus.ram_addr}) : 32'hDEAD_BEEF;

  always_ff @(posedge clk) begin
    r3_a          <= bus3.ram_en ? (32'h1000_0000 | {22'd0, bus3.ram_addr}) : 32'hDEAD_BEEF;
    r3_b          <= r3_a;
    bus3.ram_dout <= r3_b;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Starts in an IDLE cycle (T), returns in the HOLD cycle (T+7) with mem_r low.
  task automatic run_fill(input string tag, input logic [31:0] addr, input logic [9:0] base,
                          input logic [127:0] exp_line, input logic [15:0] exp_cnt,
                          input bit toggle);
    bus.mem_r    = 1'b1;
    bus.mem_addr = addr;
    #1;
    check({tag, "/T_en"}, bus.ram_en, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (toggle && k == 1) bus.mem_addr = 32'h0000_0200;
      if (k == 7) bus.mem_r = 1'b0;
      check($sformatf("%s/k%0d_en", tag, k), bus.ram_en, (k <= 4));
      if (k <= 4)
        check($sformatf("%s/k%0d_addr", tag, k), bus.ram_addr, base + k - 1);
      check($sformatf("%s/k%0d_ready", tag, k), bus.mem_ready, (k == 6));
      if (k >= 6)
        check($sformatf("%s/k%0d_line", tag, k), bus.mem_line, exp_line);
      if (k == 7)
        check({tag, "/count"}, fill_count, exp_cnt);
    end
  endtask

  initial begin
    rst           = 1'b1;
    rst3          = 1'b1;
    bus.mem_r     = 1'b0;
    bus.mem_addr  = '0;
    bus3.mem_r    = 1'b0;
    bus3.mem_addr = '0;
    tick;
    tick;
    check("rst/en",     bus.ram_en,    1'b0);
    check("rst/addr",   bus.ram_addr,  10'h000);
    check("rst/ready",  bus.mem_ready, 1'b0);
    check("rst/line",   bus.mem_line,  128'h0);
    check("rst/count",  fill_count,    16'h0000);
    check("rst3/count", fill_count3,   16'h0000);
    rst  = 1'b0;
    rst3 = 1'b0;
    tick;

    // Basic fill, then a back-to-back request in the cycle after HOLD.
    run_fill("fillA", 32'h0000_0048, 10'h010,
             128'h10000013_10000012_10000011_10000010, 16'd1, 1'b0);
    tick;
    run_fill("fillB", 32'h0000_0100, 10'h040,
             128'h10000043_10000042_10000041_10000040, 16'd2, 1'b0);
    tick;

    // Address moves to 0x200 during ISSUE; the latched 0x48 must win.
    run_fill("toggle", 32'h0000_0048, 10'h010,
             128'h10000013_10000012_10000011_10000010, 16'd3, 1'b1);
    tick;

    // Reset pulsed in T+3 of a fill.
    bus.mem_r    = 1'b1;
    bus.mem_addr = 32'h0000_0048;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst       = 1'b0;
    bus.mem_r = 1'b0;
    check("midrst/T4_en",    bus.ram_en,    1'b0);
    check("midrst/T4_ready", bus.mem_ready, 1'b0);
    check("midrst/T4_line",  bus.mem_line,  128'h0);
    check("midrst/T4_count", fill_count,    16'h0000);
    tick;
    check("midrst/T5_en",    bus.ram_en,    1'b0);
    check("midrst/T5_line",  bus.mem_line,  128'h0);
    tick;
    check("midrst/T6_ready", bus.mem_ready, 1'b0);
    run_fill("fresh", 32'h0000_0048, 10'h010,
             128'h10000013_10000012_10000011_10000010, 16'd1, 1'b0);
    tick;

    // mem_r dropped in T+3: line still fills, no ready, no count.
    bus.mem_r    = 1'b1;
    bus.mem_addr = 32'h0000_0100;
    for (int k = 1; k <= 7; k++) begin
      tick;
      if (k == 3) bus.mem_r = 1'b0;
      check($sformatf("drop/k%0d_ready", k), bus.mem_ready, 1'b0);
      if (k == 6)
        check("drop/line", bus.mem_line, 128'h10000043_10000042_10000041_10000040);
      if (k == 7)
        check("drop/count", fill_count, 16'd1);
    end
    tick;
    run_fill("afterdrop", 32'h0000_0048, 10'h010,
             128'h10000013_10000012_10000011_10000010, 16'd2, 1'b0);

    // RAM_LAT=3 build, request at 0x7C (base 0x01C).
    bus3.mem_r    = 1'b1;
    bus3.mem_addr = 32'h0000_007C;
    #1;
    check("lat3/T_en", bus3.ram_en, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick;
      check($sformatf("lat3/k%0d_en", k), bus3.ram_en, (k <= 4));
      if (k <= 4)
        check($sformatf("lat3/k%0d_addr", k), bus3.ram_addr, 10'h01C + k - 1);
      check($sformatf("lat3/k%0d_ready", k), bus3.mem_ready, (k == 8));
      if (k == 8)
        check("lat3/word3", bus3.mem_line[127:96], 32'h1000_001F);
      if (k >= 8)
        check($sformatf("lat3/k%0d_line", k), bus3.mem_line,
              128'h1000001F_1000001E_1000001D_1000001C);
      if (k == 9)
        check("lat3/count", fill_count3, 16'd1);
    end
    bus3.mem_r = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
